instr_aligner: RTL and testbench

//  Fetch-side producer for the RV32C decompressor: turns word-aligned 32-bit instruction-memory

---
 rtl/instr_aligner.sv | 73 +++++++
 tb/tb_instr_aligner.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/instr_aligner.sv
// instr_aligner: turns word-aligned imem reads into a stream of whole RV32C/RV32I instructions
module instr_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int BUF_HW = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] fetch_addr,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_data,
  output logic        fetch_ready,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        instr_is_c
);
  localparam int CW = $clog2(BUF_HW + 1);
  typedef enum logic {RUN, DROP} state_t;
  state_t state;
  logic [16*BUF_HW-1:0] mem, mem_d;
  logic [CW-1:0] count, count_d, base;
  logic [31:0] head_pc;
  logic [15:0] hw0, hw1, first_hw;
  logic [1:0] n_push, n_pop;
  logic fetch_fire, instr_fire;
  // mem is a shift FIFO: halfword 0 is always the oldest one
  always_comb begin
    hw0 = count != '0 ? mem[15:0] : 16'h0;
    hw1 = count >= CW'(2) ? mem[31:16] : 16'h0;
    instr_is_c = count != '0 && hw0[1:0] != 2'b11;
    instr_valid = instr_is_c || count >= CW'(2);
    instr_data = instr_is_c ? {16'h0, hw0} : {hw1, hw0};
    instr_pc = head_pc;
    fetch_ready = count <= CW'(BUF_HW - 2);
    fetch_fire = fetch_valid && fetch_ready;
    instr_fire = instr_valid && instr_ready;
    n_push = fetch_fire ? (state == DROP ? 2'd1 : 2'd2) : 2'd0;
    n_pop = instr_fire ? (instr_is_c ? 2'd1 : 2'd2) : 2'd0;
    first_hw = state == DROP ? fetch_data[31:16] : fetch_data[15:0];
    base = count - CW'(n_pop);
    count_d = base + CW'(n_push);
    mem_d = mem >> (16 * n_pop);
    for (int i = 0; i < BUF_HW; i++) begin
      if (n_push != 2'd0 && CW'(i) == base) mem_d[16*i +: 16] = first_hw;
      if (n_push == 2'd2 && CW'(i) == base + CW'(1)) mem_d[16*i +: 16] = fetch_data[31:16];
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem <= '0;
      count <= '0;
      fetch_addr <= RESET_PC & ~32'h3;
      head_pc <= RESET_PC;
      state <= RESET_PC[1] ? DROP : RUN;
    end else if (flush) begin
      count <= '0;
      head_pc <= flush_pc & ~32'h1;
      fetch_addr <= flush_pc & ~32'h3;
      state <= flush_pc[1] ? DROP : RUN;
    end else begin
      mem <= mem_d;
      count <= count_d;
      head_pc <= head_pc + {29'b0, n_pop, 1'b0};
      if (fetch_fire) begin
        fetch_addr <= fetch_addr + 32'd4;
        state <= RUN;
      end
    end
  end
endmodule

// File: tb/tb_instr_aligner.sv
// tb_instr_aligner: scoreboard bench; a halfword-walking reference model predicts the instruction stream
module tb_instr_aligner;
  logic clk = 0, reset_n = 0;
  logic [31:0] fetch_addr, fetch_data = 0, flush_pc = 0, instr_data, instr_pc;
  logic fetch_valid = 0, fetch_ready, flush = 0, instr_valid, instr_ready = 0, instr_is_c;
  typedef struct { logic [31:0] pc; logic [31:0] data; logic c; } exp_t;
  exp_t exp_q[$];
  logic [31:0] rom [256];
  logic [31:0] lo = 0, hi = 0;
  int n_checks = 0, n_fail = 0, accepted = 0;
  instr_aligner #(.RESET_PC(32'h0), .BUF_HW(4)) dut (
    .clk(clk), .reset_n(reset_n), .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
    .fetch_data(fetch_data), .fetch_ready(fetch_ready), .flush(flush), .flush_pc(flush_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .instr_pc(instr_pc), .instr_is_c(instr_is_c)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [15:0] rom_hw(input logic [31:0] pc);
    logic [31:0] w;
    w = rom[pc[9:2]];
    return pc[1] ? w[31:16] : w[15:0];
  endfunction
  task automatic model(input logic [31:0] from, input logic [31:0] upto);
    logic [31:0] pc;
    logic [15:0] h;
    exp_t e;
    pc = from;
    while (pc < upto) begin
      h = rom_hw(pc);
      if (h[1:0] != 2'b11) begin
        e.pc = pc; e.data = {16'h0, h}; e.c = 1; exp_q.push_back(e); pc += 2;
      end else if (pc + 4 <= upto) begin
        e.pc = pc; e.data = {rom_hw(pc + 2), h}; e.c = 0; exp_q.push_back(e); pc += 4;
      end else break;
    end
  endtask
  task automatic step(input logic rdy, input logic srv, input logic fl = 0);
    exp_t e;
    @(negedge clk);
    flush = fl;
    instr_ready = rdy;
    fetch_valid = srv && fetch_addr >= lo && fetch_addr < hi;
    fetch_data = rom[fetch_addr[9:2]];
    if (fetch_valid && fetch_ready) accepted++;
    if (instr_valid && rdy && !fl) begin
      if (exp_q.size() == 0) check("extra_instr", instr_pc, 32'hffff_ffff);
      else begin
        e = exp_q.pop_front();
        check("pc", instr_pc, e.pc);
        check("data", instr_data, e.data);
        check("is_c", {31'b0, instr_is_c}, {31'b0, e.c});
      end
    end
  endtask
  task automatic drain(input int n);
    repeat (n) step(1, 1);
    check("drain", exp_q.size(), 0);
  endtask
  task automatic reset_dut();
    @(negedge clk);
    reset_n = 0; fetch_valid = 0; instr_ready = 0; flush = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    exp_q.delete();
  endtask
  task automatic load(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3);
    rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'h0;
    reset_dut();
    check("rst_valid", {31'b0, instr_valid}, 0);
    check("rst_addr", fetch_addr, 0);
    check("rst_ready", {31'b0, fetch_ready}, 1);
    check("rst_pc", instr_pc, 0);
    check("rst_data", instr_data, 0);
    check("rst_is_c", {31'b0, instr_is_c}, 0);
    load(32'h0000_0013, 32'h4501_4485, 0, 0); lo = 0; hi = 8;
    model(0, 8);
    drain(12);
    reset_dut();
    load(32'h81B3_4485, 32'h4501_0020, 0, 0); lo = 0; hi = 8;
    model(0, 8);
    drain(12);
    reset_dut();
    load(32'h0000_0013, 32'h4501_4485, 32'h81B3_4485, 32'h4501_0020); lo = 0; hi = 16;
    model(0, 16);
    accepted = 0;
    repeat (10) step(0, 1);
    step(0, 0);
    check("bp_accepted", accepted, 2);
    check("bp_fetch_ready", {31'b0, fetch_ready}, 0);
    check("bp_fetch_addr", fetch_addr, 32'h8);
    drain(40);
    rom[8'h40] = 32'h4501_0001; lo = 32'h100; hi = 32'h104;
    flush_pc = 32'h102;
    step(1, 0, 1);
    step(1, 1);
    check("fl_addr", fetch_addr, 32'h100);
    check("fl_valid", {31'b0, instr_valid}, 0);
    model(32'h102, 32'h104);
    drain(10);
    reset_dut();
    load(32'h0000_0013, 32'h4501_4485, 0, 0); lo = 0; hi = 8;
    step(1, 1);
    flush_pc = 32'h200; rom[8'h80] = 32'h0000_4485;
    step(1, 1, 1);
    check("fl_coincide", {30'b0, instr_valid, fetch_valid && fetch_ready}, 32'h3);
    exp_q.delete(); lo = 32'h200; hi = 32'h204;
    step(1, 1);
    check("fl2_addr", fetch_addr, 32'h200);
    check("fl2_valid", {31'b0, instr_valid}, 0);
    model(32'h200, 32'h204);
    drain(10);
    reset_dut();
    load(32'h0000_0013, 32'h4501_4485, 32'h81B3_4485, 32'h4501_0020); lo = 0; hi = 16;
    repeat (6) step(0, 1);
    check("full_ready", {31'b0, fetch_ready}, 0);
    check("full_valid", {31'b0, instr_valid}, 1);
    @(negedge clk);
    reset_n = 0; fetch_valid = 0;
    #1;
    check("arst_valid", {31'b0, instr_valid}, 0);
    check("arst_addr", fetch_addr, 0);
    check("arst_pc", instr_pc, 0);
    @(negedge clk);
    reset_n = 1;
    exp_q.delete();
    model(0, 16);
    drain(40);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
